serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder built around one full-adder cell and a carry flip-flop. Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock. It sits directly on top of the full-adder stage: it holds operands and carry, sequences them through the cell, and assembles the cell's sum/carry outputs into a parallel result. It is handshaked with start/busy/done.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- ci  input  1  carry-in; captured on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; result valid
- s  output  WIDTH  registered sum; holds last result
- co  output  1  registered carry-out; holds last result

## Operation
- States:
  - IDLE: waiting.
  - RUN: processing, exactly WIDTH cycles.
  - DONE: one cycle.
- IDLE -> RUN when start=1 at a clock edge. On that edge:
  - a_sh <= a, b_sh <= b, carry <= ci.
  - bit counter <= 0; sum shift register <= 0.
- RUN, each edge:
  - Full-adder evaluation: sbit = a_sh[0]^b_sh[0]^carry; cnext = majority(a_sh[0], b_sh[0], carry).
  - carry <= cnext.
  - a_sh and b_sh shift right by one.
  - sbit shifts into the MSB of the sum shift register, which shifts right, so after WIDTH shifts bit 0 holds the first-computed bit.
  - counter increments.
- RUN -> DONE on the edge where counter == WIDTH-1. On that same edge:
  - s <= final sum shift contents, including that edge's sbit.
  - co <= cnext.
- DONE -> IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE; there is no queuing. Operand changes after capture have no effect.
- s and co change only on the RUN->DONE edge and on reset. Between results they hold their value.
- Arithmetic: {co, s} = a + b + ci, computed modulo 2^(WIDTH+1). There is no overflow flag.
- WIDTH=1: RUN lasts one cycle and the counter is trivially 0.

## Timing
- Reset values (rst_n=0 at an edge): state IDLE, busy=0, done=0, s=0, co=0, counter=0, carry=0, shift registers=0.
- Reset mid-RUN or in DONE aborts the operation: no done pulse, s/co cleared to 0.
- busy = (state==RUN), decoded from registered state. done = (state==DONE).
- Latency, with start accepted at edge 0:
  - busy=1 during cycles 1..WIDTH.
  - done=1 during cycle WIDTH+1.
  - s/co are new from cycle WIDTH+1 onward.
- Throughput: a start is accepted at the earliest in cycle WIDTH+2 (back in IDLE). One operation every WIDTH+2 cycles.
- start held high continuously: a new operation is accepted on every IDLE cycle. The done pulse still appears once per operation.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, ci=0, start pulse at edge 0 -> busy high for cycles 1..8; done pulse in cycle 9; s=0x96, co=0.
- WIDTH=8, a=0xFF, b=0x01, ci=0 -> s=0x00, co=1. Then a=0xFF, b=0xFF, ci=1 -> s=0xFF, co=1. Then a=0, b=0, ci=0 -> s=0x00, co=0, and done fires each time.
- Start at edge 0 with a=0x12, b=0x34. At cycle 3, change a to 0xFF and pulse start again -> a single done in cycle 9; s=0x46, co=0; no second operation begins.
- Start with a=0xAA, b=0x55, ci=1. Assert rst_n=0 at cycle 4 for one edge -> busy=0, done never pulses, s=0, co=0. Next start with a=0x01, b=0x01, ci=0 -> s=0x02 after 9 cycles.
- start held high constantly with a=0x80, b=0x80, ci=0 -> done pulses at cycles 9, 19, 29, ... (period WIDTH+2 = 10 cycles); each result is s=0x00, co=1.
- WIDTH=1, all 8 combinations of {ci,a,b} -> {co,s} matches the full-adder truth table (000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11); done in cycle 2 after each start. Also run ≥1000 random WIDTH=8 operations checked against a+b+ci.

Source files
------------

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for the serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (output start, a, b, ci, input busy, done, s, co);
  modport slave  (input start, a, b, ci, output busy, done, s, co);
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell plus carry flop, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next, s_q;
  logic             carry, co_q, sbit, cnext;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full-adder cell
  assign sbit  = a_sh[0] ^ b_sh[0] ^ carry;
  assign cnext = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // New sum bit enters at the MSB so the first-computed bit ends up at bit 0
  always_comb begin
    sum_next = sum_sh >> 1;
    sum_next[WIDTH-1] = sbit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      co_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.ci;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          carry  <= cnext;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          if (cnt == LAST) begin
            s_q  <= sum_next;
            co_q <= cnext;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder at WIDTH 8 and 1
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] result(input bit narrow);
    if (narrow) return {62'd0, bus1.co, bus1.s};
    return {55'd0, bus8.co, bus8.s};
  endfunction

  // One operation: start pulse, then watch busy/done timing against cycle numbers
  // counted from the accepting edge, and compare the result with plain addition.
  task automatic op(input bit narrow, input logic [7:0] a, input logic [7:0] b,
                    input logic ci, input bit disturb, input string tag);
    int         w, n, done_at, bad_busy;
    logic [8:0] exp;
    logic       bz, dn;
    w = narrow ? 1 : 8;
    exp = narrow ? (9'(a[0]) + 9'(b[0]) + 9'(ci)) : (9'(a) + 9'(b) + 9'(ci));
    @(negedge clk);
    if (narrow) begin bus1.a = a[0]; bus1.b = b[0]; bus1.ci = ci; bus1.start = 1'b1; end
    else        begin bus8.a = a;    bus8.b = b;    bus8.ci = ci; bus8.start = 1'b1; end
    @(negedge clk);
    bus1.start = 1'b0;
    bus8.start = 1'b0;
    n = 1; done_at = 0; bad_busy = 0;
    while (done_at == 0 && n < 40) begin
      bz = narrow ? bus1.busy : bus8.busy;
      dn = narrow ? bus1.done : bus8.done;
      if (bz != (n <= w)) bad_busy++;
      if (dn) done_at = n;
      if (disturb && n == 3) begin
        bus8.a = 8'hFF;
        bus8.start = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      if (done_at == 0) begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(w + 1));
    check({tag, "_busy_window"}, 64'(bad_busy), 64'd0);
    check({tag, "_sum"}, result(narrow), 64'(exp));
    @(negedge clk);
    dn = narrow ? bus1.done : bus8.done;
    bz = narrow ? bus1.busy : bus8.busy;
    check({tag, "_done_pulse"}, 64'(dn), 64'd0);
    check({tag, "_no_restart"}, 64'(bz), 64'd0);
  endtask

  initial begin
    int done_cycles[$];
    int stray;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
    repeat (3) @(negedge clk);
    check("reset8", {bus8.busy, bus8.done, bus8.co, bus8.s}, 64'd0);
    check("reset1", {bus1.busy, bus1.done, bus1.co, bus1.s}, 64'd0);
    rst_n = 1'b1;

    op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, "a5a_b3c");
    op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "ff_01");
    op(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, "ff_ff_ci");
    op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "zero");
    op(1'b0, 8'h12, 8'h34, 1'b0, 1'b1, "ignore_start");

    // Reset in the middle of a run aborts it and clears the held result
    @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.ci = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_reset", {bus8.busy, bus8.done, bus8.co, bus8.s}, 64'd0);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) stray++;
    end
    check("midrun_reset_quiet", 64'(stray), 64'd0);
    op(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, "after_reset");

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.ci = 1'b0; bus8.start = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (bus8.done) begin
        done_cycles.push_back(n);
        check("held_sum", {bus8.co, bus8.s}, 64'h100);
      end
    end
    bus8.start = 1'b0;
    check("held_count", 64'(done_cycles.size()), 64'd3);
    for (int i = 0; i < done_cycles.size() && i < 3; i++)
      check("held_period", 64'(done_cycles[i]), 64'(9 + 10 * i));
    repeat (12) @(negedge clk);

    // WIDTH=1 full-adder truth table
    for (int v = 0; v < 8; v++)
      op(1'b1, 8'(v[1]), 8'(v[0]), v[2], 1'b0, "w1_truth");

    for (int i = 0; i < 1000; i++)
      op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
